// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : Asynchronous serial transmitter. Accepts bytes over a
//             valid/ready handshake and shifts them out LSB-first as start,
//             data, optional even parity and stop bits. Each bit cell lasts
//             exactly one baud_tick period.
//  Options  : define UART_TX_PARITY_EN to append an even-parity bit.
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx #(
    parameter int DATA_BITS = 8,   // 5..8
    parameter int STOP_BITS = 1    // 1 or 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int               CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic             ONE_STOP  = (STOP_BITS == 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] hold_reg;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 stop_cnt;
    logic                 pending;
`ifdef UART_TX_PARITY_EN
    // Running XOR of the data bits already placed on the line.
    logic                 parity_acc;
`endif

    logic accept;
    logic final_stop;

    // Handshake completes on any edge where both sides agree.
    assign accept     = tx_valid & tx_ready;
    // The stop bit currently on the line is the last of the frame.
    assign final_stop = (stop_cnt == LAST_STOP);

    // Frame sequencer; tx, tx_ready and busy are all registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            pending    <= 1'b0;
            shift_reg  <= '0;
            hold_reg   <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_acc <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // A tick coinciding with acceptance is deliberately
                    // ignored: SYNC waits for the next one.
                    if (accept) begin
                        shift_reg <= tx_data;
                        tx_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SYNC;
                    end
                end

                SYNC: begin
                    if (baud_tick) begin
                        tx    <= 1'b0;
                        state <= START;
                    end
                end

                START: begin
                    if (baud_tick) begin
                        tx      <= shift_reg[0];
                        bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                        parity_acc <= shift_reg[0];
`endif
                        state   <= DATA;
                    end
                end

                DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= parity_acc;
                            state <= PARITY;
`else
                            tx       <= 1'b1;
                            stop_cnt <= 1'b0;
                            tx_ready <= ONE_STOP;
                            state    <= STOP;
`endif
                        end else begin
                            shift_reg <= shift_reg >> 1;
                            tx        <= shift_reg[1];
                            bit_cnt   <= bit_cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
                            parity_acc <= parity_acc ^ shift_reg[1];
`endif
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_tick) begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        tx_ready <= ONE_STOP;
                        state    <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (baud_tick) begin
                        if (!final_stop) begin
                            // Entering the final stop bit opens the early
                            // acceptance window.
                            stop_cnt <= stop_cnt + 1'b1;
                            tx_ready <= 1'b1;
                        end else if (pending) begin
                            // Chain straight into the next start bit.
                            shift_reg <= hold_reg;
                            pending   <= 1'b0;
                            tx        <= 1'b0;
                            tx_ready  <= 1'b0;
                            state     <= START;
                        end else if (accept) begin
                            // Accepted on the very edge the frame ends: the
                            // start bit must wait for the following tick.
                            shift_reg <= tx_data;
                            tx_ready  <= 1'b0;
                            state     <= SYNC;
                        end else begin
                            tx_ready <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end else if (accept) begin
                        hold_reg <= tx_data;
                        pending  <= 1'b1;
                        tx_ready <= 1'b0;
                    end
                end

                default: begin
                    tx       <= 1'b1;
                    tx_ready <= 1'b1;
                    busy     <= 1'b0;
                    pending  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Directed self-checking bench for uart_tx. Expected line bits
//             are queued at acceptance and compared tick by tick.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_A = 1 + 8 + PAR + 1;
    localparam int FRAME_B = 1 + 8 + PAR + 2;

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic [2:0] tick_cnt = 3'd0;
    logic       baud_tick;

    logic [7:0] data_a  = 8'h00;
    logic       valid_a = 1'b0;
    logic       ready_a, tx_a, busy_a;
    logic [7:0] data_b  = 8'h00;
    logic       valid_b = 1'b0;
    logic       ready_b, tx_b, busy_b;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    // Free-running prescaler: one tick every 8 clocks.
    always @(posedge clk) tick_cnt <= tick_cnt + 3'd1;
    assign baud_tick = (tick_cnt == 3'd7);

    uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .baud_tick(baud_tick),
        .tx_data(data_a), .tx_valid(valid_a), .tx_ready(ready_a),
        .tx(tx_a), .busy(busy_a)
    );

    uart_tx #(.DATA_BITS(8), .STOP_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .baud_tick(baud_tick),
        .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b),
        .tx(tx_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start, data LSB first, even parity if built, stops.
    task automatic push_frame(input logic [7:0] b, input int stops);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
        if (PAR == 1) exp_q.push_back(^b);
        for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
    endtask

    // Return 1 ns after the next clock edge on which baud_tick is high.
    task automatic wait_tick();
        bit found = 1'b0;
        for (int n = 0; n < 64 && !found; n++) begin
            @(negedge clk);
            if (baud_tick) begin
                @(posedge clk);
                #1;
                found = 1'b1;
            end
        end
        if (!found) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_bits(input bit use_b, input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            wait_tick();
            if (exp_q.size() == 0) chk("queue_empty", 32'd0, 32'd1);
            else chk(tag, use_b ? tx_b : tx_a, exp_q.pop_front());
        end
    endtask

    task automatic send_a(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        data_a  = b;
        valid_a = 1'b1;
        while (!ready_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_a_ready", ready_a, 1);
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        chk("accept_a_busy", busy_a, 1);
        chk("accept_a_ready_low", ready_a, 0);
        chk("accept_a_tx_idle", tx_a, 1);
        push_frame(b, 1);
    endtask

    // Full frame on dut_a followed by the return to idle.
    task automatic frame_a(input logic [7:0] b, input string tag);
        send_a(b);
        check_bits(1'b0, FRAME_A - 1, tag);
        chk("ready_before_stop", ready_a, 0);
        check_bits(1'b0, 1, tag);
        chk("ready_at_stop", ready_a, 1);
        chk("busy_at_stop", busy_a, 1);
        wait_tick();
        chk("idle_busy", busy_a, 0);
        chk("idle_tx", tx_a, 1);
        chk("idle_ready", ready_a, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_a", tx_a, 1);
        chk("rst_ready_a", ready_a, 1);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_tx_b", tx_b, 1);
        chk("rst_ready_b", ready_b, 1);
        chk("rst_busy_b", busy_b, 0);
        @(negedge clk);
        reset = 1'b0;

        // Idle line for 50 cycles
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            chk("idle50_tx", tx_a, 1);
            chk("idle50_ready", ready_a, 1);
            chk("idle50_busy", busy_a, 0);
        end

        // Single frames with distinct patterns
        frame_a(8'h55, "frame_55");
        frame_a(8'h07, "frame_07");
        frame_a(8'hFF, "frame_ff");

        // Acceptance on the same edge as a tick
        n = 0;
        @(negedge clk);
        while (!baud_tick && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("coinc_aligned", baud_tick, 1);
        data_a  = 8'h3C;
        valid_a = 1'b1;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        chk("coinc_tx_high", tx_a, 1);
        chk("coinc_busy", busy_a, 1);
        push_frame(8'h3C, 1);
        check_bits(1'b0, FRAME_A, "coinc_frame");
        wait_tick();
        chk("coinc_idle_busy", busy_a, 0);

        // Back-to-back frames, valid held, two stop bits
        @(negedge clk);
        data_b  = 8'hA5;
        valid_b = 1'b1;
        n = 0;
        while (!ready_b && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        data_b = 8'h3C;
        chk("b2b_first_accept", ready_b, 0);
        push_frame(8'hA5, 2);
        check_bits(1'b1, FRAME_B - 1, "b2b_frame1");
        chk("b2b_ready_first_stop", ready_b, 0);
        check_bits(1'b1, 1, "b2b_frame1_stop");
        chk("b2b_ready_final_stop", ready_b, 1);
        @(posedge clk);
        #1;
        valid_b = 1'b0;
        chk("b2b_second_accept", ready_b, 0);
        push_frame(8'h3C, 2);
        check_bits(1'b1, FRAME_B, "b2b_frame2");
        chk("b2b_ready_end", ready_b, 1);
        wait_tick();
        chk("b2b_idle_busy", busy_b, 0);
        chk("b2b_idle_tx", tx_b, 1);

        // Asynchronous reset in the middle of the data bits
        send_a(8'h00);
        check_bits(1'b0, 4, "rst_pre");
        chk("rst_pre_tx_low", tx_a, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_tx", tx_a, 1);
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_ready", ready_a, 1);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        frame_a(8'hC3, "frame_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
